fifo_drain_ser: RTL and testbench

Downstream drain stage for the 16-bit synchronous FIFO. It pops one word at a time via the FIFO's pop/empty handshake and shifts it out MSB-first on a single-bit serial line framed by `ser_frame`. Each bit is held for a programmable number of clock cycles. It is the sole consumer of the FIFO and sits between the FIFO and the off-block serial link.

---
 rtl/fifo_drain_ser_pkg.sv | 20 ++
 rtl/fifo_drain_ser_bit_timer.sv | 36 +++
 rtl/fifo_drain_ser.sv | 120 ++++++++++++
 tb/tb_fifo_drain_ser.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_drain_ser_pkg.sv
// fifo_drain_ser_pkg: shared types and defaults for the FIFO drain serializer.
package fifo_drain_ser_pkg;

  localparam int unsigned WIDTH_DEFAULT = 16;
  localparam int unsigned DIV_DEFAULT   = 4;
  localparam int unsigned WORD_CNT_W    = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    PARITY
  } state_t;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_drain_ser_bit_timer.sv
// ser_bit_timer: per-bit period timer for fifo_drain_ser.
// Holds the div_cnt down-counter; flags the first and last cycle of each bit period.
module ser_bit_timer
  import fifo_drain_ser_pkg::*;
#(
  parameter int unsigned DIV = DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic bit_stb,
  output logic period_end
);

  localparam int unsigned     DW     = cnt_width(DIV);
  localparam logic [DW-1:0]   RELOAD = DW'(DIV - 1);

  logic [DW-1:0] div_cnt;

  // Preset on load, then count down through each bit period and reload at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (load) begin
      div_cnt <= RELOAD;
    end else if (run) begin
      if (div_cnt == '0) div_cnt <= RELOAD;
      else               div_cnt <= div_cnt - DW'(1);
    end
  end

  assign bit_stb    = run && (div_cnt == RELOAD);
  assign period_end = run && (div_cnt == '0);

endmodule

// File: rtl/fifo_drain_ser.sv
// fifo_drain_ser: pops words from the synchronous FIFO and shifts them out
// MSB-first on ser_out, framed by ser_frame, each bit held DIV cycles.
// Optional macro FIFO_DRAIN_SER_PARITY_EN appends one even-parity bit period.
module fifo_drain_ser
  import fifo_drain_ser_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned DIV   = DIV_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_pop,
  input  logic [WIDTH-1:0]      fifo_data,
  output logic                  ser_out,
  output logic                  ser_frame,
  output logic                  ser_bit_stb,
  output logic                  busy,
  output logic [WORD_CNT_W-1:0] word_cnt
);

  localparam int unsigned BW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic             timer_load;
  logic             timer_run;
  logic             period_end;
`ifdef FIFO_DRAIN_SER_PARITY_EN
  logic             par;
`endif

  assign fifo_pop   = (state == IDLE) && enable && !fifo_empty;
  assign timer_load = (state == LOAD);
`ifdef FIFO_DRAIN_SER_PARITY_EN
  assign timer_run  = (state == SHIFT) || (state == PARITY);
`else
  assign timer_run  = (state == SHIFT);
`endif

  ser_bit_timer #(
    .DIV (DIV)
  ) u_bit_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .run        (timer_run),
    .bit_stb    (ser_bit_stb),
    .period_end (period_end)
  );

  // Word sequencing: pop, capture, shift out bit by bit, count completed words.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
`ifdef FIFO_DRAIN_SER_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (enable && !fifo_empty) state <= LOAD;
        end
        LOAD: begin
          shreg   <= fifo_data;
          bit_cnt <= BW'(WIDTH - 1);
`ifdef FIFO_DRAIN_SER_PARITY_EN
          par     <= ^fifo_data;
`endif
          state   <= SHIFT;
        end
        SHIFT: begin
          if (period_end) begin
            if (bit_cnt == '0) begin
`ifdef FIFO_DRAIN_SER_PARITY_EN
              state    <= PARITY;
`else
              state    <= IDLE;
              word_cnt <= word_cnt + WORD_CNT_W'(1);
`endif
            end else begin
              shreg   <= {shreg[WIDTH-2:0], 1'b0};
              bit_cnt <= bit_cnt - BW'(1);
            end
          end
        end
`ifdef FIFO_DRAIN_SER_PARITY_EN
        PARITY: begin
          if (period_end) begin
            state    <= IDLE;
            word_cnt <= word_cnt + WORD_CNT_W'(1);
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // Serial line decode from the registered state; quiet outside a frame.
  always_comb begin
    ser_out = 1'b0;
    case (state)
      SHIFT:   ser_out = shreg[WIDTH-1];
`ifdef FIFO_DRAIN_SER_PARITY_EN
      PARITY:  ser_out = par;
`endif
      default: ser_out = 1'b0;
    endcase
  end

  assign ser_frame = timer_run;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_fifo_drain_ser.sv
// tb_fifo_drain_ser: two serializers (DIV=4 and DIV=1) fed from behavioural
// FIFOs, checked cycle by cycle against an expected-waveform queue per word.
module tb_fifo_drain_ser;

  localparam int unsigned W = 16;
`ifdef FIFO_DRAIN_SER_PARITY_EN
  localparam int unsigned NB = W + 1;
`else
  localparam int unsigned NB = W;
`endif

  typedef struct packed {
    logic busy;
    logic frame;
    logic sout;
    logic stb;
    logic last;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          fifo_empty  [2];
  logic [W-1:0]  fifo_data   [2];
  logic          fifo_pop    [2];
  logic          ser_out     [2];
  logic          ser_frame   [2];
  logic          ser_bit_stb [2];
  logic          busy        [2];
  logic [15:0]   word_cnt    [2];

  logic [W-1:0]  fq [2][$];
  ent_t          eq [2][$];
  logic [15:0]   exp_wc [2];
  int unsigned   pops [2];
  int unsigned   n_cmp = 0;
  int unsigned   n_bad = 0;

  fifo_drain_ser #(.WIDTH(W), .DIV(4)) u_div4 (
    .clk(clk), .rst(rst), .enable(enable),
    .fifo_empty(fifo_empty[0]), .fifo_pop(fifo_pop[0]), .fifo_data(fifo_data[0]),
    .ser_out(ser_out[0]), .ser_frame(ser_frame[0]), .ser_bit_stb(ser_bit_stb[0]),
    .busy(busy[0]), .word_cnt(word_cnt[0])
  );

  fifo_drain_ser #(.WIDTH(W), .DIV(1)) u_div1 (
    .clk(clk), .rst(rst), .enable(enable),
    .fifo_empty(fifo_empty[1]), .fifo_pop(fifo_pop[1]), .fifo_data(fifo_data[1]),
    .ser_out(ser_out[1]), .ser_frame(ser_frame[1]), .ser_bit_stb(ser_bit_stb[1]),
    .busy(busy[1]), .word_cnt(word_cnt[1])
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned div_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  // Expected waveform of one word: a LOAD cycle, then NB bit periods of DIV cycles.
  task automatic expect_word(input int i, input logic [W-1:0] w);
    ent_t        e;
    int unsigned d;
    d = div_of(i);
    e = '0;
    e.busy = 1'b1;
    eq[i].push_back(e);
    for (int unsigned k = 0; k < NB * d; k++) begin
      int unsigned b;
      b       = k / d;
      e.busy  = 1'b1;
      e.frame = 1'b1;
      e.sout  = (b < W) ? w[W-1-b] : ^w;
      e.stb   = ((k % d) == 0);
      e.last  = (k == NB * d - 1);
      eq[i].push_back(e);
    end
  endtask

  task automatic push(input logic [W-1:0] w);
    for (int i = 0; i < 2; i++) begin
      fq[i].push_back(w);
      fifo_empty[i] = 1'b0;
    end
  endtask

  // One clock: check outputs at negedge, then serve pops just after posedge.
  task automatic step();
    logic pop_q [2];
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      ent_t e;
      logic exp_pop;
      if (eq[i].size() != 0) begin
        e       = eq[i].pop_front();
        exp_pop = 1'b0;
      end else begin
        e       = '0;
        exp_pop = enable && (fq[i].size() != 0);
      end
      check($sformatf("outs%0d", i),
            {27'd0, busy[i], ser_frame[i], ser_out[i], ser_bit_stb[i], fifo_pop[i]},
            {27'd0, e.busy, e.frame, e.sout, e.stb, exp_pop});
      check($sformatf("wcnt%0d", i), {16'd0, word_cnt[i]}, {16'd0, exp_wc[i]});
      if (e.last) exp_wc[i] = exp_wc[i] + 16'd1;
      if (exp_pop) expect_word(i, fq[i][0]);
      pop_q[i] = fifo_pop[i];
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (pop_q[i] && (fq[i].size() != 0)) begin
        fifo_data[i] = fq[i].pop_front();
        pops[i]++;
      end
      fifo_empty[i] = (fq[i].size() == 0);
    end
  endtask

  task automatic drain(input string tag, input int unsigned budget);
    int unsigned n;
    n = 0;
    while ((eq[0].size() != 0 || eq[1].size() != 0 ||
            fq[0].size() != 0 || fq[1].size() != 0) && n < budget) begin
      step();
      n++;
    end
    check(tag, {31'd0, n < budget}, 32'd1);
  endtask

  task automatic wait_pop(input string tag);
    int unsigned n;
    n = 0;
    while (eq[0].size() == 0 && n < 10) begin
      step();
      n++;
    end
    check(tag, {31'd0, eq[0].size() != 0}, 32'd1);
  endtask

  initial begin
    int unsigned p0;
    int unsigned p1;
    rst    = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      fifo_empty[i] = 1'b1;
      fifo_data[i]  = '0;
      exp_wc[i]     = '0;
      pops[i]       = 0;
    end
    repeat (3) step();
    rst = 1'b1;
    repeat (2) step();

    // Single word
    push(16'hA5C3);
    enable = 1'b1;
    drain("single_drain", 200);
    check("single_pops", pops[0], 1);
    check("single_wcnt", {16'd0, word_cnt[0]}, 32'd1);

    // Back-to-back words
    p0 = pops[0];
    p1 = pops[1];
    push(16'h0001);
    push(16'h8000);
    drain("b2b_drain", 400);
    check("b2b_pops4", pops[0] - p0, 2);
    check("b2b_pops1", pops[1] - p1, 2);
    check("b2b_wcnt", {16'd0, word_cnt[1]}, 32'd3);

    // Empty guard
    p0 = pops[0];
    repeat (50) step();
    check("empty_pops", pops[0] - p0, 0);

    // Enable dropped at bit 5 of the DIV=4 unit
    p0 = pops[0];
    push(16'h1234);
    push(16'hBEEF);
    wait_pop("drop_popwait");
    repeat (1 + 5 * 4) step();
    enable = 1'b0;
    repeat (120) step();
    check("drop_pops", pops[0] - p0, 1);
    enable = 1'b1;
    drain("drop_drain", 400);

    // Parity-sensitive words
    push(16'h0007);
    push(16'h0003);
    drain("par_drain", 400);

    // Randomised traffic with enable toggling
    repeat (400) begin
      if ($urandom_range(0, 7) == 0) push(W'($urandom));
      enable = ($urandom_range(0, 3) != 0);
      step();
    end
    enable = 1'b1;
    drain("rand_drain", 10000);

    // Reset mid-word at bit 8 of the DIV=4 unit
    push(16'h5A3C);
    wait_pop("rst_popwait");
    repeat (1 + 8 * 4) step();
    #2;
    rst    = 1'b0;
    enable = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_outs%0d", i),
            {28'd0, ser_out[i], ser_frame[i], busy[i], ser_bit_stb[i]}, 32'd0);
      check($sformatf("rst_wcnt%0d", i), {16'd0, word_cnt[i]}, 32'd0);
      eq[i].delete();
      exp_wc[i] = '0;
    end
    repeat (2) step();
    rst = 1'b1;
    p0 = pops[0];
    push(16'h0F0F);
    enable = 1'b1;
    drain("rst_drain", 200);
    check("rst_pops", pops[0] - p0, 1);
    check("rst_wcnt", {16'd0, word_cnt[0]}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
